// File: rtl/pinball_pkg.sv
// Shared constants for the pinball game controller: round state encoding and
// the upper bound on the number of players the score/ball arrays hold.
package pinball_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_ROLL  = 3'd2;
    localparam logic [2:0] ST_GET   = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int MAX_PLAYERS = 4;

endpackage

// File: rtl/pinball_game_ctrl_edge.sv
// Hole sensor front end: two-flop synchroniser per sensor, a history flop for
// rising-edge detection, and a lowest-index-wins one-hot priority encode.
module hole_edge_detect
    import pinball_pkg::*;
#(
    parameter int N_HOLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HOLES-1:0] hole_in,
    output logic               any_edge,
    output logic [N_HOLES-1:0] hit
);

    logic [N_HOLES-1:0] sync1_q, sync1_d;
    logic [N_HOLES-1:0] sync2_q, sync2_d;
    logic [N_HOLES-1:0] hist_q, hist_d;
    logic [N_HOLES-1:0] edge_vec;

    // Shift each sensor through the synchroniser and into the history flop every cycle
    always_comb begin
        sync1_d = hole_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Synchroniser and history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    // Rising edges, keeping only the lowest-index one when several coincide
    always_comb begin
        edge_vec = sync2_q & ~hist_q;
        hit      = '0;
        for (int i = N_HOLES - 1; i >= 0; i--) begin
            if (edge_vec[i]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
        any_edge = |edge_vec;
    end

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game controller: round FSM, per-player ball and score accounting,
// roll timeout, settle delay and winner selection at game end.
module pinball_game_ctrl
    import pinball_pkg::*;
#(
    parameter int N_HOLES      = 8,
    parameter int BALLS        = 8,
    parameter int N_PLAYERS    = 1,
    parameter int SCORE_W      = 15,
    parameter int BASE_PTS     = 1,
    parameter int BONUS_PTS    = 10,
    parameter int SETTLE_CYC   = 200_000_000,
    parameter int ROLL_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_p,
    input  logic               launch_p,
    input  logic [N_HOLES-1:0] hole_in,
    input  logic [N_HOLES-1:0] bonus_mask,
    output logic [2:0]         state,
    output logic [1:0]         player,
    output logic [3:0]         balls_left,
    output logic [SCORE_W-1:0] score,
    output logic [N_HOLES-1:0] hole_hit,
    output logic               hit_valid,
    output logic               miss,
    output logic [1:0]         winner,
    output logic               game_over
);

    localparam logic [31:0] SETTLE_LAST  = (SETTLE_CYC > 1) ? 32'(SETTLE_CYC - 1) : 32'd0;
    localparam logic [31:0] TIMEOUT_LAST = (ROLL_TIMEOUT > 1) ? 32'(ROLL_TIMEOUT - 1) : 32'd0;
    localparam logic [31:0] SCORE_MAX    = 32'((64'd1 << SCORE_W) - 64'd1);
    localparam logic [3:0]  BALLS_INIT   = 4'(BALLS);
    localparam logic [1:0]  LAST_PLAYER  = 2'(N_PLAYERS - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         player_q, player_d;
    logic [3:0]         balls_q [MAX_PLAYERS];
    logic [3:0]         balls_d [MAX_PLAYERS];
    logic [SCORE_W-1:0] score_q [MAX_PLAYERS];
    logic [SCORE_W-1:0] score_d [MAX_PLAYERS];
    logic [N_HOLES-1:0] hole_hit_q, hole_hit_d;
    logic               hit_valid_q, hit_valid_d;
    logic               miss_q, miss_d;
    logic [1:0]         winner_q, winner_d;
    logic [31:0]        cnt_q, cnt_d;

    logic               any_edge;
    logic [N_HOLES-1:0] hit_oh;
    logic [31:0]        pts;
    logic [31:0]        score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [3:0]         ball_dec;
    logic [1:0]         next_player;
    logic [1:0]         best_idx;
    logic [SCORE_W-1:0] best_score;

    hole_edge_detect #(
        .N_HOLES(N_HOLES)
    ) u_edge (
        .clk     (clk),
        .reset   (reset),
        .hole_in (hole_in),
        .any_edge(any_edge),
        .hit     (hit_oh)
    );

    // Turn bookkeeping: saturating score add, non-wrapping ball decrement, next player
    always_comb begin
        pts         = (|(hit_oh & bonus_mask)) ? 32'(BONUS_PTS) : 32'(BASE_PTS);
        score_sum   = 32'(score_q[player_q]) + pts;
        score_sat   = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        ball_dec    = (balls_q[player_q] != 4'd0) ? balls_q[player_q] - 4'd1 : 4'd0;
        next_player = (player_q == LAST_PLAYER) ? 2'd0 : player_q + 2'd1;
    end

    // Highest score wins; strict compare keeps ties on the lowest index
    always_comb begin
        best_idx   = 2'd0;
        best_score = score_q[0];
        for (int i = 1; i < N_PLAYERS; i++) begin
            if (score_q[i] > best_score) begin
                best_score = score_q[i];
                best_idx   = 2'(i);
            end
        end
    end

    // Round state machine and the state it updates on each transition
    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        balls_d     = balls_q;
        score_d     = score_q;
        hole_hit_d  = hole_hit_q;
        hit_valid_d = 1'b0;
        miss_d      = 1'b0;
        winner_d    = winner_q;
        cnt_d       = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    for (int i = 0; i < MAX_PLAYERS; i++) begin
                        score_d[i] = '0;
                        balls_d[i] = BALLS_INIT;
                    end
                    player_d = 2'd0;
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (launch_p) begin
                    state_d = ST_ROLL;
                end
            end
            ST_ROLL: begin
                if (any_edge) begin
                    state_d           = ST_GET;
                    hole_hit_d        = hit_oh;
                    hit_valid_d       = 1'b1;
                    score_d[player_q] = score_sat;
                    balls_d[player_q] = ball_dec;
                end else if ((ROLL_TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
                    state_d           = ST_GET;
                    hole_hit_d        = '0;
                    miss_d            = 1'b1;
                    balls_d[player_q] = ball_dec;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_GET: begin
                if (cnt_q == SETTLE_LAST) begin
                    if (balls_q[next_player] == 4'd0) begin
                        state_d  = ST_OVER;
                        winner_d = best_idx;
                    end else begin
                        player_d = next_player;
                        state_d  = ST_ARMED;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_OVER: begin
                if (start_p) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            player_q    <= 2'd0;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                balls_q[i] <= 4'd0;
                score_q[i] <= '0;
            end
            hole_hit_q  <= '0;
            hit_valid_q <= 1'b0;
            miss_q      <= 1'b0;
            winner_q    <= 2'd0;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            balls_q     <= balls_d;
            score_q     <= score_d;
            hole_hit_q  <= hole_hit_d;
            hit_valid_q <= hit_valid_d;
            miss_q      <= miss_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign state      = state_q;
    assign player     = player_q;
    assign balls_left = balls_q[player_q];
    assign score      = score_q[player_q];
    assign hole_hit   = hole_hit_q;
    assign hit_valid  = hit_valid_q;
    assign miss       = miss_q;
    assign winner     = winner_q;
    assign game_over  = (state_q == ST_OVER);

endmodule
